// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit (AND/OR/XOR/NAND) with an optional
// accumulate mode. Each result can feed the next beat in place of operand B.
// Valid/ready handshakes on both sides and a wrapping output beat counter.
//
// Handshake rule (both ports): a beat transfers on a rising edge where
// valid & ready are both high. The producer holds valid and its payload
// stable until that transfer. ready may depend on the consumer's ready,
// but never on the producer's valid.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [CW-1:0]    beats
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Stage 1 holding register
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s1_acc_en;

  // Running result used in place of B when accumulating
  logic [WIDTH-1:0] acc_reg;

  // Pipeline control
  logic             s2_free;
  logic             s1_move;
  logic             in_fire;
  logic             out_fire;

  // Stage 2 datapath
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] r;

  // Advance control: S2 frees when it is empty or its beat is being taken.
  // in_ready therefore sees out_ready combinationally, but never in_valid.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_move  = s1_valid && s2_free;
    in_ready = !s1_valid || s1_move;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Select operand B, then apply the operation that was latched with the beat
  always_comb begin
    bb = s1_acc_en ? acc_reg : s1_b;
    r  = '0;
    unique case (s1_op)
      OP_AND:  r = s1_a & bb;
      OP_OR:   r = s1_a | bb;
      OP_XOR:  r = s1_a ^ bb;
      OP_NAND: r = ~(s1_a & bb);
      default: r = '0;
    endcase
  end

  // Stage 1: capture the operand beat on an input handshake.
  // The slot empties when its beat moves on and nothing new arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_AND;
      s1_acc_en <= 1'b0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= op;
      s1_acc_en <= acc_en;
    end else if (s1_move) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2: load the result. The accumulator follows every load, so an
  // accumulate beat always chains from the previous transferred beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b1;
      acc_reg   <= '0;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out       <= r;
      out_zero  <= (r == '0);
      acc_reg   <= r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count completed output handshakes; wraps naturally at 2^CW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats <= '0;
    end else if (out_fire) begin
      beats <= beats + CW'(1);
    end
  end

endmodule
